// File: rtl/cpu_run_ctrl.sv
// Run/pause/single-step controller for a debug CPU: debounced buttons drive a
// four-state FSM that gates the CPU clock enable and stops on a PC breakpoint.
module cpu_run_ctrl #(
    parameter int unsigned DB_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic        cpu_stop,
    output logic [1:0]  state,
    output logic [31:0] run_cycles
);

    localparam int unsigned CW = $clog2(DB_CYC + 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_BRK  = 2'b11
    } st_t;

    st_t st;

    // Index 0 is the run button, index 1 the step button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [CW-1:0] cnt [2];

    logic run_p;
    logic step_p;
    logic first;
    logic bp_hit;

    assign btn_raw = {btn_step, btn_run};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_q   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYC - 1)) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign run_p  = db[0] & ~db_q[0];
    assign step_p = db[1] & ~db_q[1];

    // first masks the breakpoint for the first RUN cycle so a resume from the
    // breakpoint PC does not immediately re-break.
    assign bp_hit = bp_en && (pc == bp_addr) && !first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= ST_STOP;
            first <= 1'b0;
        end else begin
            case (st)
                ST_STOP, ST_BRK: begin
                    if (run_p) begin
                        st    <= ST_RUN;
                        first <= 1'b1;
                    end else if (step_p) begin
                        st <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    first <= 1'b0;
                    if (run_p) begin
                        st <= ST_STOP;
                    end else if (bp_hit) begin
                        st <= ST_BRK;
                    end
                end
                ST_STEP: st <= ST_STOP;
                default: st <= ST_STOP;
            endcase
        end
    end

    // Enable and stop are decoded from the asynchronously reset state so that
    // reset removes the CPU enable without waiting for a clock edge.
    assign cpu_en   = ((st == ST_RUN) && !bp_hit) || (st == ST_STEP);
    assign cpu_stop = (st == ST_STOP) || (st == ST_BRK);
    assign state    = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles <= '0;
        end else if (cpu_en) begin
            run_cycles <= run_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with a window-based debounce model and
// a behavioural run/step/breakpoint reference.
module tb_cpu_run_ctrl;

    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_run;
    logic        btn_step;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic        cpu_stop;
    logic [1:0]  state;
    logic [31:0] run_cycles;

    int n_chk  = 0;
    int n_fail = 0;
    logic preload = 1'b0;

    cpu_run_ctrl #(.DB_CYC(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .cpu_stop   (cpu_stop),
        .state      (state),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: 0=STOP 1=RUN 2=STEP 3=BRK
    int          m_st;
    logic        m_first;
    logic [31:0] m_cyc;
    logic [1:0]  pipe_r, pipe_s;
    logic [DB-1:0] win_r, win_s;
    logic        lvl_r, lvl_s, mp_r, mp_s;
    logic        exp_hit, exp_en;

    assign exp_hit = bp_en && (pc == bp_addr) && !m_first;
    assign exp_en  = (m_st == 1 && !exp_hit) || (m_st == 2);

    // The debounced level flips once the last DB synchronized samples all disagree with it.
    function automatic logic settle(input logic [DB-1:0] w, input logic lvl);
        if (lvl) return (w == '0) ? 1'b0 : 1'b1;
        return (w == '1) ? 1'b1 : 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin : mdl
        logic [DB-1:0] nw_r, nw_s;
        logic nl_r, nl_s;
        int nst;
        if (rst) begin
            m_st <= 0; m_first <= 1'b0; m_cyc <= '0;
            pipe_r <= '0; pipe_s <= '0; win_r <= '0; win_s <= '0;
            lvl_r <= 1'b0; lvl_s <= 1'b0; mp_r <= 1'b0; mp_s <= 1'b0;
        end else begin
            nst = m_st;
            case (m_st)
                0, 3: if (mp_r) nst = 1; else if (mp_s) nst = 2;
                1:    if (mp_r) nst = 0; else if (exp_hit) nst = 3;
                default: nst = 0;
            endcase
            if (nst == 1 && m_st != 1) m_first <= 1'b1;
            else if (m_st == 1) m_first <= 1'b0;
            m_st <= nst;
            if (preload) m_cyc <= 32'hFFFF_FFFF;
            else if (exp_en) m_cyc <= m_cyc + 32'd1;
            nw_r = {win_r[DB-2:0], pipe_r[1]};
            nw_s = {win_s[DB-2:0], pipe_s[1]};
            win_r <= nw_r; win_s <= nw_s;
            pipe_r <= {pipe_r[0], btn_run};
            pipe_s <= {pipe_s[0], btn_step};
            nl_r = settle(nw_r, lvl_r);
            nl_s = settle(nw_s, lvl_s);
            mp_r <= nl_r & ~lvl_r; mp_s <= nl_s & ~lvl_s;
            lvl_r <= nl_r; lvl_s <= nl_s;
        end
    end

    task automatic hold_btns(input logic r, input logic s, input int hold, input int gap);
        btn_run = r; btn_step = s;
        repeat (hold) @(negedge clk);
        btn_run = 1'b0; btn_step = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_chk++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
        n_chk++; if (cpu_stop !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_stop got %b want 1", cpu_stop); end
        n_chk++; if (run_cycles !== 32'h0) begin n_fail++; $display("FAIL reset_run_cycles got %h want 0", run_cycles); end
    endtask

    task automatic test_run_press();
        hold_btns(1'b1, 1'b0, 10, 8);
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_press_state got %0d want 1", state); end
        n_chk++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL run_press_cpu_en got %b want 1", cpu_en); end
        n_chk++; if (run_cycles !== m_cyc) begin n_fail++; $display("FAIL run_press_cycles got %h want %h", run_cycles, m_cyc); end
        hold_btns(1'b1, 1'b0, 2, 10);
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL glitch_state got %0d want 1", state); end
        hold_btns(1'b1, 1'b0, 10, 8);
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL pause_state got %0d want 0", state); end
        n_chk++; if (cpu_stop !== 1'b1) begin n_fail++; $display("FAIL pause_cpu_stop got %b want 1", cpu_stop); end
        n_chk++; if (run_cycles !== m_cyc) begin n_fail++; $display("FAIL pause_cycles got %h want %h", run_cycles, m_cyc); end
    endtask

    task automatic test_step();
        int en_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        btn_step = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 9) btn_step = 1'b0;
            if (cpu_en) en_cnt++;
        end
        n_chk++; if (en_cnt != 1) begin n_fail++; $display("FAIL step_en_cycles got %0d want 1", en_cnt); end
        n_chk++; if (run_cycles !== 32'd1) begin n_fail++; $display("FAIL step_cycles got %h want 1", run_cycles); end
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL step_state got %0d want 0", state); end
        n_chk++; if (cpu_stop !== 1'b1) begin n_fail++; $display("FAIL step_cpu_stop got %b want 1", cpu_stop); end
    endtask

    task automatic test_breakpoint();
        logic seen = 1'b0;
        bp_en = 1'b1; bp_addr = 32'h0000_3010; pc = 32'h0000_1000;
        hold_btns(1'b1, 1'b0, 10, 8);
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL bp_run_state got %0d want 1", state); end
        pc = 32'h0000_3010;
        #1;
        n_chk++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL bp_hit_cpu_en got %b want 0", cpu_en); end
        @(negedge clk);
        n_chk++; if (state !== 2'b11) begin n_fail++; $display("FAIL bp_brk_state got %0d want 3", state); end
        n_chk++; if (cpu_stop !== 1'b1) begin n_fail++; $display("FAIL bp_brk_cpu_stop got %b want 1", cpu_stop); end
        btn_run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 9) btn_run = 1'b0;
            if (!seen && m_st == 1) begin
                seen = 1'b1;
                n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL bp_resume_state got %0d want 1", state); end
                n_chk++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume_cpu_en got %b want 1", cpu_en); end
                pc = 32'h0000_3014;
            end
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL bp_resume_timeout got no RUN want RUN within 20 cycles"); end
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL bp_no_rebreak got %0d want 1", state); end
        hold_btns(1'b1, 1'b0, 10, 8);
        bp_en = 1'b0;
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL bp_pause_state got %0d want 0", state); end
    endtask

    task automatic test_coincide();
        hold_btns(1'b1, 1'b1, 10, 8);
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL both_state got %0d want 1", state); end
        hold_btns(1'b0, 1'b1, 10, 8);
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL step_in_run got %0d want 1", state); end
        n_chk++; if (run_cycles !== m_cyc) begin n_fail++; $display("FAIL both_cycles got %h want %h", run_cycles, m_cyc); end
        hold_btns(1'b1, 1'b0, 10, 8);
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL both_pause got %0d want 0", state); end
    endtask

    task automatic test_wrap();
        force dut.run_cycles = 32'hFFFF_FFFF;
        preload = 1'b1;
        #1 release dut.run_cycles;
        @(negedge clk);
        preload = 1'b0;
        n_chk++; if (run_cycles !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffffffff", run_cycles); end
        hold_btns(1'b0, 1'b1, 10, 8);
        n_chk++; if (run_cycles !== 32'h0) begin n_fail++; $display("FAIL wrap_cycles got %h want 0", run_cycles); end
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL wrap_state got %0d want 0", state); end
    endtask

    task automatic test_async_reset();
        hold_btns(1'b1, 1'b0, 10, 8);
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL areset_pre_state got %0d want 1", state); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL areset_cpu_en got %b want 0", cpu_en); end
        n_chk++; if (cpu_stop !== 1'b1) begin n_fail++; $display("FAIL areset_cpu_stop got %b want 1", cpu_stop); end
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL areset_state got %0d want 0", state); end
        n_chk++; if (run_cycles !== 32'h0) begin n_fail++; $display("FAIL areset_cycles got %h want 0", run_cycles); end
        btn_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL held_btn_state got %0d want 1", state); end
        repeat (10) @(negedge clk);
        btn_run = 1'b0;
        repeat (8) @(negedge clk);
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL held_btn_single got %0d want 1", state); end
        hold_btns(1'b1, 1'b0, 10, 8);
    endtask

    task automatic test_random();
        int hr = 0;
        int hs = 0;
        bp_addr = 32'h0000_3010; bp_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_chk++; if (state !== 2'(m_st)) begin n_fail++; $display("FAIL rand_state cyc %0d got %0d want %0d", c, state, m_st); end
            n_chk++; if (cpu_en !== exp_en) begin n_fail++; $display("FAIL rand_cpu_en cyc %0d got %b want %b", c, cpu_en, exp_en); end
            n_chk++; if (cpu_stop !== (m_st == 0 || m_st == 3)) begin n_fail++; $display("FAIL rand_cpu_stop cyc %0d got %b", c, cpu_stop); end
            n_chk++; if (run_cycles !== m_cyc) begin n_fail++; $display("FAIL rand_cycles cyc %0d got %h want %h", c, run_cycles, m_cyc); end
            if (hr == 0) begin btn_run = ($urandom_range(0, 2) == 0); hr = int'($urandom_range(1, 12)); end
            else hr--;
            if (hs == 0) begin btn_step = ($urandom_range(0, 2) == 0); hs = int'($urandom_range(1, 12)); end
            else hs--;
            case ($urandom_range(0, 3))
                0:       pc = bp_addr;
                1:       pc = bp_addr + 32'd4;
                default: pc = $urandom;
            endcase
            if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
        end
        btn_run = 1'b0; btn_step = 1'b0; bp_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
        bp_en = 1'b0; bp_addr = '0; pc = '0;
        #1 rst = 1'b1;
        #1 test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_run_press();
        test_step();
        test_breakpoint();
        test_coincide();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter DB_CYC, default 1000000, is the number of consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz); the bench overrides it to 4.
REQ-002 clk  input  1  system clock; all state is updated on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 btn_run  input  1  raw run/pause push button, asynchronous to clk.
REQ-005 btn_step  input  1  raw single-step push button, asynchronous to clk.
REQ-006 bp_en  input  1  breakpoint enable, quasi-static switch.
REQ-007 bp_addr  input  32  breakpoint PC value.
REQ-008 pc  input  32  current CPU PC from the debug bus.
REQ-009 cpu_en  output  1  CPU clock enable; the CPU advances one cycle per clk edge while this is high.
REQ-010 cpu_stop  output  1  high when the CPU is halted, driving the stop LED.
REQ-011 state  output  2  current FSM state code.
REQ-012 run_cycles  output  32  count of enabled CPU cycles.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
- The debouncer holds a debounced level.
- It counts consecutive cycles in which the synchronized value differs from the debounced level.
- At a count of DB_CYC the debounced level flips and the counter clears.
- Any cycle of agreement clears the counter.
REQ-014 A rising edge of a debounced level SHALL produce a one-cycle pulse: run_p for btn_run, step_p for btn_step; falling edges produce nothing.
REQ-015 FSM state codes SHALL be STOP=00, RUN=01, STEP=10, BRK=11.
REQ-016 In STOP: run_p -> RUN; step_p -> STEP; both in the same cycle -> RUN (run has priority).
REQ-017 In RUN:
- run_p -> STOP.
- bp_hit -> BRK.
- bp_hit and run_p in the same cycle -> STOP.
- step_p is ignored.
REQ-018 In STEP the FSM SHALL unconditionally go to STOP on the next edge, so cpu_en is high for exactly one cycle per step; run_p and step_p arriving in STEP are dropped.
REQ-019 In BRK: run_p -> RUN; step_p -> STEP; both in the same cycle -> RUN.
REQ-020 bp_hit SHALL equal bp_en AND (pc == bp_addr) AND NOT first, where first is a flag that:
- is set on every transition into RUN;
- clears after one cycle in RUN.
This lets execution resume from the breakpoint PC without re-breaking.
REQ-021 cpu_en SHALL be combinational: (state==RUN AND NOT bp_hit) OR state==STEP. The breaking cycle is therefore never enabled.
REQ-022 cpu_stop SHALL be high exactly when state is STOP or BRK.
REQ-023 run_cycles SHALL increment by 1 on each edge where cpu_en is high, and wrap from 0xFFFFFFFF to 0.
REQ-024 A pc change while in STOP or BRK SHALL have no effect on state.

Reset
REQ-025 While rst is high, independent of clk:
- state=STOP, cpu_en=0, cpu_stop=1, run_cycles=0;
- synchronizer flops, debounced levels, debounce counters, edge registers and first all cleared.
REQ-026 Reset asserted mid-RUN or mid-STEP SHALL drop cpu_en within the same cycle, with no clock edge required.
REQ-027 After rst deasserts, a button already held high SHALL generate exactly one pulse, once debounced.

Verification
REQ-028 DB_CYC=4: hold btn_run high for 10 cycles from STOP -> exactly one run_p, state=RUN, cpu_en=1; a 2-cycle glitch on btn_run -> no pulse.
REQ-029 From STOP, press btn_step -> cpu_en high for exactly 1 cycle, run_cycles 0->1, state returns to STOP (00), cpu_stop=1.
REQ-030 bp_en=1, bp_addr=0x00003010; in RUN, drive pc to 0x00003010 -> cpu_en=0 in that cycle, state=BRK (11) next edge. Press run -> RUN with pc still 0x00003010, no re-break, cpu_en=1.
REQ-031 btn_run and btn_step pulses coincide in STOP -> state=RUN. A step press in RUN -> no state change.
REQ-032 Preload run_cycles to 0xFFFFFFFF (force), one enabled cycle -> 0x00000000.
REQ-033 Assert rst mid-RUN between clock edges -> cpu_en=0 and cpu_stop=1 immediately, state=00, run_cycles=0.
